// File: rtl/serial_sub_add.sv
// Bit-serial LSB-first adder/subtractor: one full adder plus a carry/borrow flop.
// Operations start with START, run WIDTH bit-steps under BUSY, and finish with a DONE pulse.
module serial_sub_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             SUB_ADD,
  input  logic             B_CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D_S,
  output logic             B_COUT
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] ra, rb, res;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             sub_q;
  logic             accept_c;
  logic             step_c;
  logic             last_c;
  logic             s_c;
  logic             c_nxt_c;
  logic [WIDTH-1:0] res_nxt_c;

  // One full-adder bit-step on the current LSBs
  assign s_c       = ra[0] ^ rb[0] ^ c;
  assign c_nxt_c   = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign res_nxt_c = {s_c, res[WIDTH-1:1]};
  assign last_c    = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_next = ST_SHIFT;
          accept_c   = 1'b1;
        end
      end
      ST_SHIFT: begin
        step_c = 1'b1;
        if (last_c) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (START) begin
          state_next = ST_SHIFT;
          accept_c   = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; subtract runs as A + ~B + ~B_CIN
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      sub_q  <= 1'b0;
      D_S    <= '0;
      B_COUT <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      if (accept_c) begin
        ra    <= A;
        rb    <= SUB_ADD ? ~B : B;
        c     <= SUB_ADD ? ~B_CIN : B_CIN;
        cnt   <= '0;
        sub_q <= SUB_ADD;
      end else if (step_c) begin
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        c   <= c_nxt_c;
        res <= res_nxt_c;
        cnt <= cnt + CW'(1);
        if (last_c) begin
          D_S    <= res_nxt_c;
          B_COUT <= sub_q ? ~c_nxt_c : c_nxt_c;
        end
      end
      BUSY <= (state_next == ST_SHIFT);
      DONE <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_serial_sub_add.sv
// Self-checking bench for serial_sub_add: directed vectors, handshake corners,
// and random operations against an arithmetic reference model.
module tb_serial_sub_add;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         START;
  logic         SUB_ADD;
  logic         B_CIN;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D_S;
  logic         B_COUT;

  int checks   = 0;
  int failures = 0;

  serial_sub_add #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .SUB_ADD(SUB_ADD),
    .B_CIN(B_CIN), .A(A), .B(B), .BUSY(BUSY), .DONE(DONE),
    .D_S(D_S), .B_COUT(B_COUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_d;
    logic         exp_bo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                output logic [W-1:0] d, output logic bo);
    int x;
    if (!sub) begin
      x  = int'(a) + int'(b) + int'(cin);
      d  = W'(x);
      bo = (x >= (1 << W));
    end else begin
      x  = int'(a) - int'(b) - int'(cin);
      d  = W'(x);
      bo = (x < 0);
    end
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    A = a; B = b; B_CIN = cin; SUB_ADD = sub; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Counts edges after the accepting edge until DONE; flags BUSY/DONE overlap
  task automatic wait_done(output int lat);
    int overlap;
    lat = 0;
    overlap = 0;
    while (!DONE && lat < 40) begin
      if (BUSY && DONE) overlap++;
      @(posedge CLK); #1;
      lat++;
    end
    if (BUSY && DONE) overlap++;
    check("busy_done_overlap", 32'(overlap), 0);
  endtask

  initial begin
    vec_t         vecs[$];
    int           lat;
    logic [W-1:0] d_exp;
    logic         bo_exp;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           stray;

    RESET_N = 1'b0; START = 1'b0; SUB_ADD = 1'b0; B_CIN = 1'b0; A = '0; B = '0;

    // Reset and idle
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_ds", 32'(D_S), 0);
    check("rst_bcout", 32'(B_COUT), 0);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_busy", 32'(BUSY), 0);
    check("idle_done", 32'(DONE), 0);
    check("idle_ds", 32'(D_S), 0);

    // Directed vectors
    vecs.push_back('{8'd17,  8'd2,   1'b0, 1'b0, 8'd19,  1'b0});
    vecs.push_back('{8'd17,  8'd2,   1'b0, 1'b1, 8'd15,  1'b0});
    vecs.push_back('{8'd17,  8'd2,   1'b1, 1'b0, 8'd20,  1'b0});
    vecs.push_back('{8'd17,  8'd2,   1'b1, 1'b1, 8'd14,  1'b0});
    vecs.push_back('{8'd253, 8'd3,   1'b0, 1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd128, 8'd128, 1'b0, 1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd2,   8'd3,   1'b0, 1'b1, 8'd255, 1'b1});
    vecs.push_back('{8'd1,   8'd3,   1'b0, 1'b1, 8'd254, 1'b1});
    vecs.push_back('{8'd0,   8'd0,   1'b1, 1'b1, 8'd255, 1'b1});
    vecs.push_back('{8'd255, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1});
    vecs.push_back('{8'd5,   8'd4,   1'b1, 1'b1, 8'd0,   1'b0});
    vecs.push_back('{8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      check($sformatf("vec%0d_busy", i), 32'(BUSY), 1);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), W);
      check($sformatf("vec%0d_ds", i), 32'(D_S), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_bcout", i), 32'(B_COUT), 32'(vecs[i].exp_bo));
      @(posedge CLK); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(DONE), 0);
      check($sformatf("vec%0d_hold_ds", i), 32'(D_S), 32'(vecs[i].exp_d));
    end

    // START held through SHIFT, operands scrambled after capture
    A = 8'd17; B = 8'd2; B_CIN = 1'b0; SUB_ADD = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    lat = 0;
    while (!DONE && lat < 40) begin
      A = W'($urandom); B = W'($urandom); B_CIN = 1'($urandom); SUB_ADD = 1'($urandom);
      @(posedge CLK); #1;
      lat++;
    end
    START = 1'b0;
    check("hold_latency", 32'(lat), W);
    check("hold_ds", 32'(D_S), 19);
    check("hold_bcout", 32'(B_COUT), 0);
    @(posedge CLK); #1;

    // Back-to-back: START in the DONE cycle
    start_op(8'd17, 8'd2, 1'b0, 1'b0);
    wait_done(lat);
    check("b2b_first_ds", 32'(D_S), 19);
    A = 8'd253; B = 8'd3; B_CIN = 1'b0; SUB_ADD = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("b2b_busy", 32'(BUSY), 1);
    check("b2b_done_low", 32'(DONE), 0);
    check("b2b_ds_held", 32'(D_S), 19);
    wait_done(lat);
    check("b2b_latency", 32'(lat), W);
    check("b2b_ds", 32'(D_S), 0);
    check("b2b_bcout", 32'(B_COUT), 1);
    @(posedge CLK); #1;

    // Reset at step 4 of a running 17+2
    start_op(8'd17, 8'd2, 1'b0, 1'b0);
    wait_done(lat);
    @(posedge CLK); #1;
    start_op(8'd17, 8'd2, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    check("midrst_busy", 32'(BUSY), 0);
    check("midrst_done", 32'(DONE), 0);
    check("midrst_ds", 32'(D_S), 0);
    check("midrst_bcout", 32'(B_COUT), 0);
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) stray++;
    end
    check("midrst_no_done", 32'(stray), 0);
    start_op(8'd17, 8'd2, 1'b0, 1'b0);
    wait_done(lat);
    check("midrst_fresh_ds", 32'(D_S), 19);

    // Randomized against the reference model
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, d_exp, bo_exp);
      start_op(ra, rb, rc, rs);
      wait_done(lat);
      check("rand_latency", 32'(lat), W);
      check($sformatf("rand%0d_ds a=%0d b=%0d cin=%0d sub=%0d", n, ra, rb, rc, rs),
            32'(D_S), 32'(d_exp));
      check($sformatf("rand%0d_bcout", n), 32'(B_COUT), 32'(bo_exp));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
